mdio_req_arbiter: RTL
=====================

Name: mdio_req_arbiter

Overview:
Shares one MDIO frame generator among NREQ requesters, e.g. a PHY init sequencer, a link-status poller and a software register port. Each request is a 32-bit Clause-22 frame. The block:
- picks one requester round-robin;
- launches the frame into the generator;
- tracks completion (MDC edge count for writes, data_rdy for reads);
- returns read data and status to the winning requester.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 1023, max clk cycles spent waiting for generator completion before error
PTR_W, $clog2(NREQ), width of round-robin pointer (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low; 0 = reset
req  in  NREQ  per-requester request; held high until matching done pulse
req_frame  in  32*NREQ  frame for requester i at bits [32*i+31:32*i]
grant  out  NREQ  one-hot; high for granted requester from LAUNCH through DONE
done  out  NREQ  one-cycle pulse to granted requester at end of transaction
rd_data_out  out  16  read data; valid in DONE cycle for read ops
err  out  1  valid with done; 1 = invalid frame or timeout
busy  out  1  high in every state except IDLE
gen_start  out  1  one-cycle start pulse to generator
gen_t_data  out  32  frame to generator; stable from LAUNCH until return to IDLE
gen_mdc  in  1  generator MDC output, used for bit counting
gen_data_rdy  in  1  generator read-complete flag
gen_rd_data  in  16  generator read data

Behaviour:
- Reset (reset==0 at posedge clk):
  - State goes to IDLE.
  - All outputs are 0.
  - RR pointer = 0, so requester 0 has highest priority first.
  - Edge, bit and timeout counters are cleared.
  - Applies in any state. An in-flight generator transaction is abandoned; gen_start stays 0.
- Frame fields:
  - [31:30] start, must be 01
  - [29:28] op: 01 write, 10 read
  - [27:23] phyad, [22:18] regad, [17:16] TA, [15:0] data
- FSM states: IDLE, LAUNCH, WAIT_WR, WAIT_RD, DONE.
- IDLE:
  - If req != 0, select the first set bit searching upward from ptr and wrapping modulo NREQ.
  - Register the winner index, load gen_t_data from its frame, go to LAUNCH.
  - If req == 0, stay in IDLE.
- LAUNCH (1 cycle):
  - grant[idx]=1.
  - If start!=01 or op is not in {01,10}: gen_start=0, set err flag, go to DONE.
  - Otherwise gen_start=1 for this single cycle, clear counters, go to WAIT_WR (op 01) or WAIT_RD (op 10).
- MDC edge detect: mdc_q <= gen_mdc every cycle; rising edge = gen_mdc & ~mdc_q.
- WAIT_WR:
  - Count MDC rising edges (6-bit counter).
  - When count reaches 32, go to DONE with err=0.
- WAIT_RD:
  - When gen_data_rdy==1 is sampled, capture gen_rd_data into the rd_data_out register and go to DONE with err=0.
  - MDC edges are ignored.
- Timeout:
  - In WAIT_WR/WAIT_RD, a cycle counter increments each clk.
  - When it equals TIMEOUT with completion not yet seen, go to DONE with err=1 and rd_data_out=0.
  - If completion and timeout happen in the same cycle, completion wins and err=0.
- DONE (1 cycle):
  - done[idx]=1 and grant[idx]=1; err and rd_data_out valid.
  - rd_data_out holds its value until the next DONE.
  - ptr <= (idx+1) mod NREQ. Go to IDLE.
- Request handling:
  - Deassertion of req[idx] after grant is ignored; the transaction completes.
  - Changes to req_frame after the IDLE capture are ignored.
- Latency:
  - IDLE with request to gen_start = 1 cycle.
  - Read: DONE follows the cycle gen_data_rdy is sampled.
  - Minimum request-to-next-grant gap: IDLE is always visited for 1 cycle.
- Only one transaction is in flight at a time; gen_start never pulses outside LAUNCH.

Optional Feature:
MDIO_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index always wins; ptr register is removed or held at 0.
- Undefined (default): round-robin as described above.

Test Plan:
1. req=0001, frame0=0x5006_1234 (write):
   - gen_start pulses 1 cycle after the request, gen_t_data=0x5006_1234.
   - done[0] follows 32 gen_mdc rising edges; err=0.
2. req=0100, frame2=0x6006_0000 (read):
   - The model raises gen_data_rdy with gen_rd_data=0xBEEF.
   - done[2] pulses the next cycle with rd_data_out=0xBEEF, err=0.
3. req=1111 held, all valid writes:
   - Grant order is 0,1,2,3,0; with MDIO_ARB_FIXED_PRIO_EN it is 0,0,0.
4. req=0010, frame1=0x7000_0000 (bad op):
   - No gen_start; done[1] 2 cycles after the request; err=1.
5. Read with gen_data_rdy never asserted, TIMEOUT=16:
   - done pulses after 16 WAIT cycles; err=1, rd_data_out=0.
6. reset=0 for 1 cycle during WAIT_WR:
   - All outputs 0 the next cycle; state IDLE.
   - A held req then re-launches, starting from requester 0.

Source files
------------

// File: rtl/mdio_req_arbiter.sv
// Round-robin arbiter sharing one MDIO frame generator among NREQ requesters.
// Define MDIO_ARB_FIXED_PRIO_EN for fixed priority (lowest index always wins).
module mdio_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   req_frame_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      done_o,
    output logic [15:0]          rd_data_out_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 gen_start_o,
    output logic [31:0]          gen_t_data_o,
    input  logic                 gen_mdc_i,
    input  logic                 gen_data_rdy_i,
    input  logic [15:0]          gen_rd_data_i
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitWr,
        StWaitRd,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]        frame_q, frame_d;
    logic               err_q, err_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic [5:0]         edge_cnt_q, edge_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               mdc_q;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [31:0]        win_frame;
    logic               mdc_rise;
    logic               frame_ok;
    logic               tmo_hit;

    assign mdc_rise = gen_mdc_i & ~mdc_q;
    assign frame_ok = (frame_q[31:30] == 2'b01) &&
                      ((frame_q[29:28] == 2'b01) || (frame_q[29:28] == 2'b10));
    assign tmo_hit  = (tmo_cnt_d == TMO_W'(TIMEOUT));

    // Search upward from ptr_q, wrapping modulo NREQ; first set request wins.
    always_comb begin
        int unsigned j;
        found     = 1'b0;
        win       = '0;
        win_frame = '0;
        j         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr_q) + i) % NREQ;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                win       = PTR_W'(j);
                win_frame = req_frame_i[32*j +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        frame_d     = frame_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        edge_cnt_d  = edge_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        gen_start_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    idx_d   = win;
                    frame_d = win_frame;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                edge_cnt_d = '0;
                tmo_cnt_d  = '0;
                if (!frame_ok) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    err_d       = 1'b0;
                    gen_start_o = 1'b1;
                    state_d     = (frame_q[29:28] == 2'b01) ? StWaitWr : StWaitRd;
                end
            end
            StWaitWr: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (mdc_rise) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
                // Completion takes precedence over a coincident timeout.
                if (mdc_rise && (edge_cnt_q == 6'd31)) begin
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (tmo_hit) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = StDone;
                end
            end
            StWaitRd: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (gen_data_rdy_i) begin
                    rd_data_d = gen_rd_data_i;
                    err_d     = 1'b0;
                    state_d   = StDone;
                end else if (tmo_hit) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
`ifdef MDIO_ARB_FIXED_PRIO_EN
                ptr_d = '0;
`else
                ptr_d = (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ptr_q      <= '0;
            frame_q    <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            edge_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            mdc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            edge_cnt_q <= edge_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            mdc_q      <= gen_mdc_i;
        end
    end

    always_comb begin
        grant_o = '0;
        done_o  = '0;
        if (state_q != StIdle) begin
            grant_o = NREQ'(1) << idx_q;
        end
        if (state_q == StDone) begin
            done_o = NREQ'(1) << idx_q;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign err_o         = (state_q == StDone) & err_q;
    assign rd_data_out_o = rd_data_q;
    assign gen_t_data_o  = frame_q;

endmodule
